// File: rtl/pll_lock_sequencer.sv
// PLL bring-up and supervision: drives PLL reset, qualifies the synchronised LOCK bits
// as a group with debounce, timeout and retry, and emits a system reset / READY.
module pll_lock_sequencer #(
    parameter int NUM_PLL             = 1,
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                 CLKI,
    input  logic                 RST,
    input  logic [NUM_PLL-1:0]   LOCK,
    output logic                 PLL_RST,
    output logic                 SYS_RST,
    output logic                 READY,
    output logic                 FAULT,
    output logic                 LOCK_LOST,
    output logic [((MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1)-1:0] RETRY_CNT
);

    localparam int RW  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int RCW = $clog2(RST_CYCLES);
    localparam int SCW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TCW = $clog2(LOCK_TIMEOUT_CYCLES);

    localparam logic [RCW-1:0] RST_LAST     = RCW'(RST_CYCLES - 1);
    localparam logic [SCW-1:0] STABLE_LAST  = SCW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0]  RETRY_LAST   = RW'(MAX_RETRIES);

    typedef enum logic [1:0] {
        S_PLLRST    = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_RUN       = 2'd2,
        S_FAULT     = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [NUM_PLL-1:0] sync1, sync2;
    logic               lock_all;
    logic [RCW-1:0]     rst_cnt, rst_cnt_n;
    logic [SCW-1:0]     stable_cnt, stable_cnt_n;
    logic [TCW-1:0]     timeout_cnt, timeout_cnt_n;
    logic [RW-1:0]      retry_n;
    logic               lost_n;

    // LOCK pins are asynchronous to CLKI; only the second-stage bits are trusted.
    assign lock_all = &sync2;

    always_ff @(posedge CLKI or posedge RST) begin
        if (RST) begin
            sync1       <= '0;
            sync2       <= '0;
            state       <= S_PLLRST;
            rst_cnt     <= '0;
            stable_cnt  <= '0;
            timeout_cnt <= '0;
            RETRY_CNT   <= '0;
            LOCK_LOST   <= 1'b0;
        end else begin
            sync1       <= LOCK;
            sync2       <= sync1;
            state       <= state_n;
            rst_cnt     <= rst_cnt_n;
            stable_cnt  <= stable_cnt_n;
            timeout_cnt <= timeout_cnt_n;
            RETRY_CNT   <= retry_n;
            LOCK_LOST   <= lost_n;
        end
    end

    always_comb begin
        state_n       = state;
        rst_cnt_n     = rst_cnt;
        stable_cnt_n  = stable_cnt;
        timeout_cnt_n = timeout_cnt;
        retry_n       = RETRY_CNT;
        lost_n        = LOCK_LOST;
        case (state)
            S_PLLRST: begin
                if (rst_cnt == RST_LAST) begin
                    state_n       = S_WAIT_LOCK;
                    rst_cnt_n     = '0;
                    stable_cnt_n  = '0;
                    timeout_cnt_n = '0;
                end else begin
                    rst_cnt_n = rst_cnt + RCW'(1);
                end
            end
            S_WAIT_LOCK: begin
                stable_cnt_n  = lock_all ? stable_cnt + SCW'(1) : '0;
                timeout_cnt_n = timeout_cnt + TCW'(1);
                // Qualification is tested first so it wins a same-cycle timeout.
                if (lock_all && stable_cnt == STABLE_LAST) begin
                    state_n       = S_RUN;
                    retry_n       = '0;
                    stable_cnt_n  = '0;
                    timeout_cnt_n = '0;
                end else if (timeout_cnt == TIMEOUT_LAST) begin
                    stable_cnt_n  = '0;
                    timeout_cnt_n = '0;
                    rst_cnt_n     = '0;
                    if (RETRY_CNT == RETRY_LAST) begin
                        state_n = S_FAULT;
                    end else begin
                        state_n = S_PLLRST;
                        retry_n = RETRY_CNT + RW'(1);
                    end
                end
            end
            S_RUN: begin
                if (!lock_all) begin
                    state_n   = S_PLLRST;
                    rst_cnt_n = '0;
                    lost_n    = 1'b1;
                end
            end
            S_FAULT: begin
                state_n = S_FAULT;
            end
            default: begin
                state_n = S_PLLRST;
            end
        endcase
    end

    // Outputs decode the registered state only, so RST forces them without a clock.
    assign PLL_RST = (state == S_PLLRST) || (state == S_FAULT);
    assign SYS_RST = (state != S_RUN);
    assign READY   = (state == S_RUN);
    assign FAULT   = (state == S_FAULT);

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Parametrised PLL bring-up and supervision block that sits beside one or more EHXPLLL clock multipliers (x2/x4/xN).
- Drives each PLL's RST pin and qualifies the raw LOCK outputs as a group, with debounce, timeout, retry and a fault state.
- Produces a single system reset and READY flag for all logic clocked by the PLL outputs.
- Supersedes bare LOCK wiring, which has no loss-of-lock recovery.

Parameters:
- NUM_PLL, 1: number of supervised PLLs (1..4).
- RST_CYCLES, 16: cycles PLL_RST is held high per attempt (>=2).
- LOCK_STABLE_CYCLES, 64: consecutive cycles with all locks high required to declare lock (>=1).
- LOCK_TIMEOUT_CYCLES, 4096: maximum cycles in WAIT_LOCK per attempt (> LOCK_STABLE_CYCLES).
- MAX_RETRIES, 3: re-attempts after the first failed attempt before FAULT (>=0).

Ports:
- CLKI  in  1  reference/free-running clock (must not be a supervised PLL output).
- RST  in  1  asynchronous, active-high reset. Assertion is asynchronous; deassertion is sampled on CLKI.
- LOCK  in  NUM_PLL  raw PLL lock outputs; asynchronous to CLKI.
- PLL_RST  out  1  reset to all supervised PLLs, active-high.
- SYS_RST  out  1  downstream reset, active-high.
- READY  out  1  all PLLs qualified locked.
- FAULT  out  1  retries exhausted.
- LOCK_LOST  out  1  sticky; set on any loss of lock while in RUN.
- RETRY_CNT  out  clog2(MAX_RETRIES+1) (min 1)  retries consumed in the current bring-up.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Each LOCK bit passes through a 2-flop synchroniser. lock_all = AND of the synchronised bits, giving 2 cycles of latency from the pin.
- Moore FSM. All outputs are registered or decoded from the registered state.
- States: PLLRST, WAIT_LOCK, RUN, FAULT.
- While RST is high: state=PLLRST, counters=0, RETRY_CNT=0, LOCK_LOST=0, synchronisers=0.
  - Output values: PLL_RST=1, SYS_RST=1, READY=0, FAULT=0.
- PLLRST:
  - PLL_RST=1, SYS_RST=1.
  - cnt increments each cycle. At cnt==RST_CYCLES-1, go to WAIT_LOCK and clear both counters.
  - The state lasts exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - PLL_RST=0, SYS_RST=1.
  - stable_cnt increments while lock_all=1 and clears to 0 on any cycle lock_all=0.
  - timeout_cnt increments every cycle.
  - If lock_all=1 and stable_cnt==LOCK_STABLE_CYCLES-1, go to RUN.
  - Else if timeout_cnt==LOCK_TIMEOUT_CYCLES-1:
    - if RETRY_CNT==MAX_RETRIES, go to FAULT;
    - otherwise increment RETRY_CNT and go to PLLRST.
  - If qualification and timeout occur in the same cycle, qualification wins.
- RUN:
  - PLL_RST=0, SYS_RST=0, READY=1.
  - RETRY_CNT clears on entry.
  - On any cycle with lock_all=0: set LOCK_LOST and go to PLLRST. SYS_RST reasserts the next cycle, with no debounce on loss.
- FAULT:
  - PLL_RST=1, SYS_RST=1, FAULT=1, READY=0.
  - Terminal; exits only via RST.
- LOCK_LOST is cleared only by RST. It remains set through re-lock and FAULT.
- RST asserted mid-operation in any state takes effect immediately: PLL_RST and SYS_RST go to 1 with no clock required.
- Counters saturate-free. Widths are sized to their parameter maxima, so no wrap occurs.

Test Plan:
- Bench parameters: RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2, NUM_PLL=2.
- Nominal bring-up: LOCK=2'b11 constant; release RST.
  - Required: PLL_RST high through edge 4 and low from edge 4.
  - Required: READY=1 and SYS_RST=0 after edge 12; RETRY_CNT=0, FAULT=0, LOCK_LOST=0.
- Glitchy lock: in WAIT_LOCK, drop LOCK[1] for one cycle after 5 stable cycles.
  - Required: stable_cnt restarts; READY rises 8 cycles after lock_all returns high; no retry consumed.
- Loss of lock in RUN: after READY, pulse LOCK[0] low for 1 cycle.
  - Required: SYS_RST=1, READY=0 and PLL_RST=1 for 4 cycles; LOCK_LOST=1.
  - Required: re-qualification 12 cycles later gives READY=1 with LOCK_LOST still 1.
- Exhausted retries: LOCK=0 permanently.
  - Required: RETRY_CNT steps 0→1→2 at 36-cycle intervals; FAULT=1 and PLL_RST=1 after edge 108; state is held for 500 further cycles.
- Late lock on final attempt: LOCK rises during the third attempt.
  - Required: READY=1, RETRY_CNT=0, FAULT never asserted.
- Boundary: LOCK rises so that qualification coincides with timeout (stable_cnt==7 and timeout_cnt==31 on the same edge).
  - Required: RUN entered, no retry.
- Async reset: assert RST mid-RUN between clock edges.
  - Required: SYS_RST and PLL_RST go to 1 without a clock edge; all status outputs clear.
